// File: rtl/cpc_boot_loader.sv
// cpc_boot_loader
// ROM-download front end between the mist_io ioctl byte stream and the
// zsdram write port. Writes for the selected ioctl index are filtered to
// the three 16 KB ROM banks, remapped to SDRAM pages, buffered in a small
// FIFO and retired one at a time with a request/ack handshake. The CPU is
// held in boot_reset until the image is committed plus a guard interval.
//
// Optional feature macro: BOOT_CSUM_EN (additive checksum of committed bytes
// on csum; without it csum is tied to zero).
//
// Ports
//   clk_sys         in   system clock
//   reset           in   synchronous active-high reset
//   ioctl_download  in   host download in progress
//   ioctl_index     in   download target index
//   ioctl_wr        in   one-cycle byte strobe
//   ioctl_addr      in   byte address within the image
//   ioctl_dout      in   byte data
//   ioctl_wait      out  host must stall ioctl_wr while high
//   ram_we          out  SDRAM write request, held until ram_ack
//   ram_a           out  SDRAM byte address
//   ram_din         out  SDRAM write data
//   ram_ack         in   one-cycle write-complete pulse
//   boot_reset      out  hold machine in reset
//   loaded          out  last completed download committed at least one byte
//   overflow        out  sticky: byte arrived while FIFO full
//   csum            out  additive checksum of committed bytes
//
// Top FSM
//   state   | meaning
//   S_IDLE  | no ROM download, machine free-running
//   S_LOAD  | host streaming bytes
//   S_DRAIN | host done, FIFO and write engine emptying
//   S_HOLD  | all bytes committed, guard interval counting down

module cpc_boot_loader #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] ROM_INDEX   = 8'h00,
    parameter logic [8:0] BANK0_PAGE  = 9'h000,
    parameter logic [8:0] BANK1_PAGE  = 9'h100,
    parameter logic [8:0] BANK2_PAGE  = 9'h107,
    parameter int         HOLD_CYCLES = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ram_we,
    output logic [22:0] ram_a,
    output logic [7:0]  ram_din,
    input  logic        ram_ack,
    output logic        boot_reset,
    output logic        loaded,
    output logic        overflow,
    output logic [7:0]  csum
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    CNT_WAIT = (PTR_W+1)'(FIFO_DEPTH - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD} state_t;
    typedef enum logic {W_IDLE, W_BUSY} wstate_t;

    state_t  state, state_next;
    wstate_t wstate, w_next;

    logic act, act_q, act_rise, act_fall;
    logic in_rom, accept, push, drop, pop, full, empty;
    logic w_load, start, finish, hold_load, drained_next;
    logic [8:0]        page;
    logic [30:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [PTR_W:0]    count, count_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [15:0]       commit_cnt;

    assign act      = ioctl_download & (ioctl_index == ROM_INDEX);
    assign act_rise = act & ~act_q;
    assign act_fall = ~act & act_q;

    always_comb begin
        in_rom = 1'b1;
        page   = BANK0_PAGE;
        case (ioctl_addr[24:14])
            11'd0:   page = BANK0_PAGE;
            11'd1:   page = BANK1_PAGE;
            11'd2:   page = BANK2_PAGE;
            default: in_rom = 1'b0;
        endcase
    end

    assign full   = (count == CNT_FULL);
    assign empty  = (count == '0);
    assign accept = ioctl_wr & act & in_rom;
    assign push   = accept & ~full;
    assign drop   = accept & full;
    // The head entry stays in the FIFO while its write is outstanding.
    assign pop    = (wstate == W_BUSY) & ram_ack;

    always_comb begin
        count_next = count;
        if (push & ~pop)
            count_next = count + 1'b1;
        else if (pop & ~push)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (push)
            mem[wr_ptr] <= {page, ioctl_addr[13:0], ioctl_dout};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            ioctl_wait <= (count_next >= CNT_WAIT);
        end
    end

    always_comb begin
        w_next = wstate;
        w_load = 1'b0;
        case (wstate)
            W_IDLE: if (!empty) begin
                w_next = W_BUSY;
                w_load = 1'b1;
            end
            W_BUSY: if (ram_ack)
                w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wstate  <= W_IDLE;
            ram_we  <= 1'b0;
            ram_a   <= '0;
            ram_din <= '0;
        end else begin
            wstate <= w_next;
            if (w_load) begin
                {ram_a, ram_din} <= mem[rd_ptr];
                ram_we           <= 1'b1;
            end else if (pop) begin
                ram_we <= 1'b0;
            end
        end
    end

    // Judged on next-cycle occupancy so the guard interval starts on the
    // edge that retires the final write.
    assign drained_next = (count_next == '0) & (w_next == W_IDLE);

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        hold_load  = 1'b0;
        case (state)
            S_IDLE: if (act_rise) begin
                state_next = S_LOAD;
                start      = 1'b1;
            end
            S_LOAD: if (act_fall)
                state_next = S_DRAIN;
            S_DRAIN: if (act_rise) begin
                state_next = S_LOAD;
            end else if (drained_next) begin
                state_next = S_HOLD;
                hold_load  = 1'b1;
            end
            S_HOLD: if (act_rise) begin
                state_next = S_LOAD;
                start      = 1'b1;
            end else if (hold_cnt == '0) begin
                state_next = S_IDLE;
                finish     = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state      <= S_IDLE;
            act_q      <= 1'b0;
            hold_cnt   <= '0;
            boot_reset <= 1'b0;
            loaded     <= 1'b0;
            overflow   <= 1'b0;
            commit_cnt <= '0;
        end else begin
            state <= state_next;
            act_q <= act;
            if (hold_load)
                hold_cnt <= HOLD_INIT;
            else if (state == S_HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
            if (start) begin
                boot_reset <= 1'b1;
                loaded     <= 1'b0;
                overflow   <= 1'b0;
                commit_cnt <= '0;
            end else begin
                if (finish) begin
                    boot_reset <= 1'b0;
                    loaded     <= (commit_cnt != '0);
                end
                if (drop)
                    overflow <= 1'b1;
                if (pop && commit_cnt != 16'hFFFF)
                    commit_cnt <= commit_cnt + 1'b1;
            end
        end
    end

`ifdef BOOT_CSUM_EN
    logic [7:0] csum_q;

    always_ff @(posedge clk_sys) begin
        if (reset)
            csum_q <= '0;
        else if (start)
            csum_q <= '0;
        else if (pop)
            csum_q <= csum_q + ram_din;
    end

    assign csum = csum_q;
`else
    assign csum = 8'h00;
`endif

endmodule

// File: tb/tb_cpc_boot_loader.sv
// Testbench for cpc_boot_loader: directed host downloads with an SDRAM
// responder; expected SDRAM writes are queued at issue and checked by a
// separate monitor on each ram_ack.

module tb_cpc_boot_loader;

    localparam int HOLD = 16;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'h00;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        ram_we;
    logic [22:0] ram_a;
    logic [7:0]  ram_din;
    logic        ram_ack = 1'b0;
    logic        boot_reset;
    logic        loaded;
    logic        overflow;
    logic [7:0]  csum;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    int cyc = 0;
    int last_ack_edge = 0;
    int ack_delay = 2;
    bit ack_hold = 1'b0;
    logic [30:0] exp_q[$];
    logic [30:0] e;

    cpc_boot_loader dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_we         (ram_we),
        .ram_a          (ram_a),
        .ram_din        (ram_din),
        .ram_ack        (ram_ack),
        .boot_reset     (boot_reset),
        .loaded         (loaded),
        .overflow       (overflow),
        .csum           (csum)
    );

    always #5 clk_sys = ~clk_sys;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // SDRAM responder: one-cycle ack ack_delay cycles after the request rises.
    initial begin : sdram
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk_sys);
            #1;
            ram_ack = 1'b0;
            if (ram_we === 1'b1 && !ack_hold) begin
                if (wcnt >= ack_delay - 1) begin
                    ram_ack = 1'b1;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: every completed SDRAM write must match the queue head.
    always @(negedge clk_sys) begin
        if (ram_we === 1'b1 && ram_ack === 1'b1) begin
            n_writes++;
            last_ack_edge = cyc + 1;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL ram_write: unexpected write a=%06h d=%02h, none expected", ram_a, ram_din);
            end else begin
                e = exp_q.pop_front();
                if ({ram_a, ram_din} !== e) begin
                    n_bad++;
                    $display("FAIL ram_write: got a=%06h d=%02h expected a=%06h d=%02h",
                             ram_a, ram_din, e[30:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic write_byte(input logic [24:0] addr, input logic [7:0] data,
                              input logic [22:0] exp_a, input bit commit, input bit ignore_wait);
        int n;
        n = 0;
        if (!ignore_wait) begin
            while (ioctl_wait === 1'b1 && n < 300) begin
                tick(1);
                n++;
            end
            check("host_wait_release", 32'(n < 300), 32'd1);
        end
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        if (commit)
            exp_q.push_back({exp_a, data});
        tick(1);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_boot_low(output int fell);
        int n;
        n = 0;
        fell = 0;
        while (n < 400) begin
            @(negedge clk_sys);
            if (boot_reset === 1'b0) begin
                fell = cyc;
                break;
            end
            n++;
        end
        check("boot_reset_fall_in_time", 32'(n < 400), 32'd1);
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
        check({tag, "_ram_we"},     32'(ram_we),     32'd0);
        check({tag, "_ram_a"},      32'(ram_a),      32'd0);
        check({tag, "_ram_din"},    32'(ram_din),    32'd0);
        check({tag, "_boot_reset"}, 32'(boot_reset), 32'd0);
        check({tag, "_loaded"},     32'(loaded),     32'd0);
        check({tag, "_overflow"},   32'(overflow),   32'd0);
        check({tag, "_csum"},       32'(csum),       32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int fell;
        int w0;

        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // Normal download across all three banks, ack 2 cycles after request.
        ack_delay = 2;
        ioctl_index = 8'h00;
        ioctl_download = 1'b1;
        tick(1);
        check("a_boot_reset_high", 32'(boot_reset), 32'd1);
        write_byte(25'h000000, 8'hA5, 23'h000000, 1'b1, 1'b0);
        write_byte(25'h000001, 8'h5A, 23'h000001, 1'b1, 1'b0);
        write_byte(25'h003FFF, 8'h3C, 23'h003FFF, 1'b1, 1'b0);
        write_byte(25'h004000, 8'h11, 23'h400000, 1'b1, 1'b0);
        write_byte(25'h007FFF, 8'h22, 23'h403FFF, 1'b1, 1'b0);
        write_byte(25'h008000, 8'h33, 23'h41C000, 1'b1, 1'b0);
        write_byte(25'h00BFFF, 8'h44, 23'h41FFFF, 1'b1, 1'b0);
        ioctl_download = 1'b0;
        wait_boot_low(fell);
        check("a_hold_after_last_ack", 32'(fell - last_ack_edge), 32'(HOLD));
        check("a_all_written", 32'(exp_q.size()), 32'd0);
        check("a_loaded", 32'(loaded), 32'd1);
        check("a_overflow", 32'(overflow), 32'd0);
`ifdef BOOT_CSUM_EN
        check("a_csum", 32'(csum), 32'hE5);
`else
        check("a_csum", 32'(csum), 32'h00);
`endif

        // Bank 3 byte only: discarded, nothing committed.
        w0 = n_writes;
        ioctl_download = 1'b1;
        tick(1);
        write_byte(25'h00C000, 8'h77, 23'h0, 1'b0, 1'b0);
        tick(3);
        check("b_bank3_no_ram_we", 32'(ram_we), 32'd0);
        ioctl_download = 1'b0;
        wait_boot_low(fell);
        check("b_bank3_loaded", 32'(loaded), 32'd0);
        check("b_bank3_writes", 32'(n_writes - w0), 32'd0);

        // Non-ROM index: never leaves IDLE, never writes.
        ioctl_index = 8'h01;
        ioctl_download = 1'b1;
        tick(1);
        write_byte(25'h000010, 8'h99, 23'h0, 1'b0, 1'b0);
        tick(3);
        check("c_other_idx_boot_reset", 32'(boot_reset), 32'd0);
        check("c_other_idx_ram_we", 32'(ram_we), 32'd0);
        ioctl_download = 1'b0;
        ioctl_index = 8'h00;
        tick(2);

        // Ack withheld 50 cycles, host honours ioctl_wait: nothing lost.
        ack_hold = 1'b1;
        fork
            begin
                tick(50);
                ack_hold = 1'b0;
            end
        join_none
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 3; i++)
            write_byte(25'h000020 + 25'(i), 8'h80 + 8'(i), 23'h000020 + 23'(i), 1'b1, 1'b0);
        check("d_wait_after_3", 32'(ioctl_wait), 32'd1);
        for (int i = 3; i < 8; i++)
            write_byte(25'h000020 + 25'(i), 8'h80 + 8'(i), 23'h000020 + 23'(i), 1'b1, 1'b0);
        ioctl_download = 1'b0;
        wait_boot_low(fell);
        check("d_stall_all_written", 32'(exp_q.size()), 32'd0);
        check("d_stall_overflow", 32'(overflow), 32'd0);
        check("d_stall_loaded", 32'(loaded), 32'd1);

        // Ignore ioctl_wait: 5 bytes into a 4-deep FIFO, 5th dropped.
        w0 = n_writes;
        ack_hold = 1'b1;
        ioctl_download = 1'b1;
        tick(1);
        for (int i = 0; i < 4; i++)
            write_byte(25'h004100 + 25'(i), 8'hC0 + 8'(i), 23'h400100 + 23'(i), 1'b1, 1'b1);
        write_byte(25'h004104, 8'hC4, 23'h0, 1'b0, 1'b1);
        tick(1);
        check("e_overflow_set", 32'(overflow), 32'd1);
        check("e_wait_when_full", 32'(ioctl_wait), 32'd1);
        ack_hold = 1'b0;
        ioctl_download = 1'b0;
        wait_boot_low(fell);
        check("e_exact_4_writes", 32'(n_writes - w0), 32'd4);
        check("e_overflow_sticky", 32'(overflow), 32'd1);

        // Checksum of 0xFF, 0x02, 0x10; new download clears overflow.
        ioctl_download = 1'b1;
        tick(1);
        check("f_overflow_cleared", 32'(overflow), 32'd0);
        write_byte(25'h008010, 8'hFF, 23'h41C010, 1'b1, 1'b0);
        write_byte(25'h008011, 8'h02, 23'h41C011, 1'b1, 1'b0);
        write_byte(25'h008012, 8'h10, 23'h41C012, 1'b1, 1'b0);
        ioctl_download = 1'b0;
        wait_boot_low(fell);
`ifdef BOOT_CSUM_EN
        check("f_csum", 32'(csum), 32'h11);
`else
        check("f_csum", 32'(csum), 32'h00);
`endif

        // Reset mid-LOAD with a request outstanding.
        ack_hold = 1'b1;
        ioctl_download = 1'b1;
        tick(1);
        write_byte(25'h000040, 8'h12, 23'h0, 1'b0, 1'b0);
        write_byte(25'h000041, 8'h34, 23'h0, 1'b0, 1'b0);
        tick(2);
        check("g_ram_we_before_reset", 32'(ram_we), 32'd1);
        reset = 1'b1;
        tick(1);
        check_all_zero("g_midload");
        ioctl_download = 1'b0;
        reset = 1'b0;
        ack_hold = 1'b0;
        tick(5);
        check("g_fifo_lost", 32'(ram_we), 32'd0);
        check("g_no_pending", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
